// File: rtl/fft_pixel_encoder.sv
// Converts signed complex FFT bins to 8-bit log-magnitude pixel codes.
// Three-stage pipeline (power, leading-one detect, clip) with valid/ready and frame sync.
module fft_pixel_encoder #(
  parameter int unsigned IW     = 16,
  parameter logic [8:0]  OFFSET = 9'd0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_sync,
  input  logic [IW-1:0] i_real,
  input  logic [IW-1:0] i_imag,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_sync,
  output logic [7:0]    o_pixel
);

  localparam int unsigned PW = 2 * IW;
  localparam int unsigned EW = $clog2(PW);

  logic ce;

  logic          s1_valid_q, s1_sync_q;
  logic [PW-1:0] s1_p_q;

  logic          s2_valid_q, s2_sync_q, s2_z_q;
  logic [EW-1:0] s2_e_q;
  logic [2:0]    s2_m_q;

  logic          o_valid_q, o_sync_q;
  logic [7:0]    o_pixel_q;

  assign ce      = !o_valid_q || i_ready;
  assign o_ready = ce;
  assign o_valid = o_valid_q;
  assign o_sync  = o_sync_q;
  assign o_pixel = o_pixel_q;

  // Stage 1: sum of squares; worst case 2^(2IW-1) still fits PW unsigned bits.
  logic signed [PW-1:0] re_x, im_x, sq_re, sq_im;
  logic        [PW-1:0] p_d;

  assign re_x  = {{IW{i_real[IW-1]}}, i_real};
  assign im_x  = {{IW{i_imag[IW-1]}}, i_imag};
  assign sq_re = re_x * re_x;
  assign sq_im = im_x * im_x;
  assign p_d   = $unsigned(sq_re) + $unsigned(sq_im);

  // Stage 2: leading-one position and the three mantissa bits below it.
  logic [EW-1:0] lod_e;
  logic [2:0]    lod_m;
  logic [PW+2:0] p_ext;

  always_comb begin
    lod_e = '0;
    for (int i = 0; i < PW; i++) begin
      if (s1_p_q[i]) lod_e = EW'(i);
    end
    p_ext = {s1_p_q, 3'b000};
    lod_m = p_ext[lod_e +: 3];
  end

  // Stage 3: RAW = 8*E + M is just {E, M}; subtract the floor and saturate.
  logic [15:0] raw, off;
  logic [7:0]  pix_d;

  always_comb begin
    raw   = 16'({s2_e_q, s2_m_q});
    off   = 16'(OFFSET);
    pix_d = 8'd0;
    if (s2_z_q || raw <= off) begin
      pix_d = 8'd0;
    end else if (raw - off > 16'd255) begin
      pix_d = 8'hff;
    end else begin
      pix_d = 8'(raw - off);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sync_q  <= 1'b0;
      s1_p_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sync_q  <= 1'b0;
      s2_z_q     <= 1'b0;
      s2_e_q     <= '0;
      s2_m_q     <= '0;
      o_valid_q  <= 1'b0;
      o_sync_q   <= 1'b0;
      o_pixel_q  <= '0;
    end else if (ce) begin
      s1_valid_q <= i_valid;
      s1_sync_q  <= i_sync & i_valid;
      s1_p_q     <= p_d;
      s2_valid_q <= s1_valid_q;
      s2_sync_q  <= s1_sync_q & s1_valid_q;
      s2_z_q     <= (s1_p_q == '0);
      s2_e_q     <= lod_e;
      s2_m_q     <= lod_m;
      o_valid_q  <= s2_valid_q;
      o_sync_q   <= s2_sync_q & s2_valid_q;
      o_pixel_q  <= pix_d;
    end
  end

endmodule

// File: tb/tb_fft_pixel_encoder.sv
// Bench for fft_pixel_encoder: scoreboard against an arithmetic log2 model, two OFFSET
// variants sharing one input stream, plus directed literal pixel sequences.
module tb_fft_pixel_encoder;

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_sync = 1'b0;
  logic               i_ready = 1'b1;
  logic signed [15:0] i_real = '0;
  logic signed [15:0] i_imag = '0;

  logic       o_ready, o_valid, o_sync;
  logic [7:0] o_pixel;
  logic       o_ready_b, o_valid_b, o_sync_b;
  logic [7:0] o_pixel_b;

  fft_pixel_encoder #(.IW(16), .OFFSET(9'd0)) dut0 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sync(i_sync), .i_real(i_real), .i_imag(i_imag), .o_valid(o_valid),
    .i_ready(i_ready), .o_sync(o_sync), .o_pixel(o_pixel)
  );

  fft_pixel_encoder #(.IW(16), .OFFSET(9'd16)) dut16 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_sync(i_sync), .i_real(i_real), .i_imag(i_imag), .o_valid(o_valid_b),
    .i_ready(i_ready), .o_sync(o_sync_b), .o_pixel(o_pixel_b)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int adv    = 0;

  typedef struct {
    int pix0;
    int pix16;
    bit sync;
    int stamp;
  } exp_t;

  exp_t exp_q[$];
  int   got_pix0[$];
  int   got_pix16[$];
  bit   got_sync[$];
  int   got_cyc[$];
  bit   held = 1'b0;
  int   held_pix;
  bit   held_sync;
  bit   saw_ready_low = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pixel from the log2 definition: E = floor(log2 P), M = next three bits below the MSB.
  function automatic int model_pix(input int re, input int im, input int off);
    longint p;
    int e, m, raw;
    p = longint'(re) * re + longint'(im) * im;
    if (p == 0) return 0;
    e = 0;
    while ((p >> (e + 1)) != 0) e++;
    if (e >= 3) m = int'((p >> (e - 3)) & 7);
    else        m = int'((p << (3 - e)) & 7);
    raw = 8 * e + m;
    if (raw <= off) return 0;
    if (raw - off > 255) return 255;
    return raw - off;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard: decisions taken at negedge describe the transfers of the next posedge.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_reset_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      chk("o_ready_rule", o_ready, !o_valid || i_ready);
      chk("ready_pair", o_ready_b, o_ready);
      chk("valid_pair", o_valid_b, o_valid);
      if (!o_ready) saw_ready_low = 1'b1;
      if (held && o_valid) begin
        chk("stall_pixel_stable", o_pixel, held_pix);
        chk("stall_sync_stable", o_sync, held_sync);
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = exp_q[0];
          chk("pixel_off0", o_pixel, e.pix0);
          chk("pixel_off16", o_pixel_b, e.pix16);
          chk("sync", o_sync, e.sync);
          chk("sync_b", o_sync_b, e.sync);
          chk("latency", adv, e.stamp + 3);
          if (i_ready) begin
            void'(exp_q.pop_front());
            got_pix0.push_back(int'(o_pixel));
            got_pix16.push_back(int'(o_pixel_b));
            got_sync.push_back(o_sync);
            got_cyc.push_back(cyc);
            held = 1'b0;
          end else begin
            held      = 1'b1;
            held_pix  = int'(o_pixel);
            held_sync = o_sync;
          end
        end
      end else begin
        chk("sync_idle", o_sync, 0);
        held = 1'b0;
      end
      if (i_valid && o_ready) begin
        e.pix0  = model_pix(int'(i_real), int'(i_imag), 0);
        e.pix16 = model_pix(int'(i_real), int'(i_imag), 16);
        e.sync  = i_sync;
        e.stamp = adv;
        exp_q.push_back(e);
      end
      if (o_ready) adv++;
    end
  end

  task automatic send(input int re, input int im, input bit sy);
    bit ok;
    int n;
    n = 0;
    i_valid = 1'b1;
    i_real  = 16'(re);
    i_imag  = 16'(im);
    i_sync  = sy;
    do begin
      @(negedge i_clk);
      ok = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
    i_valid = 1'b0;
    i_sync  = 1'b0;
  endtask

  task automatic bubble();
    i_valid = 1'b0;
    i_sync  = 1'b1;
    i_real  = 16'sd12345;
    @(posedge i_clk);
    #1;
    i_sync = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_logs();
    got_pix0.delete();
    got_pix16.delete();
    got_sync.delete();
    got_cyc.delete();
  endtask

  initial begin
    int exp_seq[5];
    int exp16[3];

    // Model pinned against hand-computed codes.
    chk("model_16_0", model_pix(16, 0, 0), 64);
    chk("model_3_4", model_pix(3, 4, 0), 36);
    chk("model_max", model_pix(-32768, -32768, 0), 248);
    chk("model_near_max", model_pix(-32768, -32767, 0), 247);
    chk("model_1_1_off16", model_pix(1, 1, 16), 0);

    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_pixel", o_pixel, 0);
    chk("rst_sync", o_sync, 0);
    chk("rst_ready", o_ready, 1);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single zero bin: o_valid after exactly three enabled edges.
    send(0, 0, 1'b0);
    chk("t1_valid_e0", o_valid, 0);
    chk("t1_ready_e0", o_ready, 1);
    @(posedge i_clk); #1;
    chk("t1_valid_e1", o_valid, 0);
    chk("t1_ready_e1", o_ready, 1);
    @(posedge i_clk); #1;
    chk("t1_valid_e2", o_valid, 1);
    chk("t1_pixel", o_pixel, 0);
    chk("t1_sync", o_sync, 0);
    chk("t1_ready_e2", o_ready, 1);
    @(posedge i_clk); #1;
    chk("t1_valid_e3", o_valid, 0);
    drain();
    clear_logs();

    // Back-to-back stream, OFFSET=0 and OFFSET=16 views.
    send(16, 0, 1'b0);
    send(3, 4, 1'b0);
    send(-32768, -32768, 1'b0);
    send(-32768, -32767, 1'b0);
    send(1, 0, 1'b0);
    drain();
    exp_seq = '{64, 36, 248, 247, 0};
    chk("t2_count", got_pix0.size(), 5);
    for (int k = 0; k < 5 && k < got_pix0.size(); k++) chk("t2_pixel", got_pix0[k], exp_seq[k]);
    for (int k = 1; k < 5 && k < got_cyc.size(); k++) chk("t2_spacing", got_cyc[k] - got_cyc[k-1], 1);
    clear_logs();

    send(16, 0, 1'b0);
    send(1, 1, 1'b0);
    send(-32768, -32768, 1'b0);
    drain();
    exp16 = '{48, 0, 232};
    chk("t3_count", got_pix16.size(), 3);
    for (int k = 0; k < 3 && k < got_pix16.size(); k++) chk("t3_pixel16", got_pix16[k], exp16[k]);
    clear_logs();

    // Eight bins with a five-cycle downstream stall in the middle.
    saw_ready_low = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(2 << k, 0, (k == 0 || k == 4));
      end
      begin
        repeat (2) @(posedge i_clk);
        #2 i_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #2 i_ready = 1'b1;
      end
    join
    drain();
    chk("t4_ready_dropped", saw_ready_low, 1);
    chk("t4_count", got_pix0.size(), 8);
    for (int k = 0; k < 8 && k < got_pix0.size(); k++) begin
      chk("t4_pixel", got_pix0[k], 16 * (k + 1));
      chk("t4_sync", got_sync[k], (k == 0 || k == 4));
    end
    clear_logs();

    // Reset with bins in flight.
    send(16, 0, 1'b1);
    send(3, 4, 1'b0);
    send(8, 0, 1'b0);
    i_reset_n = 1'b0;
    @(posedge i_clk); #1;
    chk("t5_valid_after_rst", o_valid, 0);
    chk("t5_pixel_after_rst", o_pixel, 0);
    i_reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      chk("t5_no_stale", o_valid, 0);
    end
    clear_logs();
    send(16, 0, 1'b0);
    drain();
    chk("t5_count", got_pix0.size(), 1);
    if (got_pix0.size() > 0) chk("t5_pixel", got_pix0[0], 64);
    clear_logs();

    // Alternating valid/bubble keeps the 1/0 spacing at the output.
    for (int k = 0; k < 4; k++) begin
      send(2 << k, 0, 1'b0);
      bubble();
    end
    drain();
    chk("t6_count", got_pix0.size(), 4);
    for (int k = 0; k < 4 && k < got_pix0.size(); k++) chk("t6_pixel", got_pix0[k], 16 * (k + 1));
    for (int k = 1; k < 4 && k < got_cyc.size(); k++) chk("t6_spacing", got_cyc[k] - got_cyc[k-1], 2);
    for (int k = 0; k < 4 && k < got_sync.size(); k++) chk("t6_sync", got_sync[k], 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
